// File: rtl/query_pkg.sv
// Shared types and constants for the query enumerator and its solution FIFO.
package query_pkg;

  localparam int ATOM_BITS = 3;
  localparam int NUM_ATOMS = 6;

  typedef logic [ATOM_BITS-1:0] atom_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Symbol codes of the friends program
  localparam atom_t SYM_ALICE   = 3'd0;
  localparam atom_t SYM_BOB     = 3'd1;
  localparam atom_t SYM_CHARLIE = 3'd2;
  localparam atom_t SYM_DAVE    = 3'd3;
  localparam atom_t SYM_EVE     = 3'd4;
  localparam atom_t SYM_HATES   = 3'd5;

endpackage

// File: rtl/query_enumerator_sol_fifo.sv
// First-word fall-through solution FIFO with flush and an occupancy counter.
// Storage is rounded up to a power of two so a depth of 1 still has a valid pointer.
module sol_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [2**PTR_W];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             do_push, do_pop;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  assign do_pop  = pop && !empty && !flush;
  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

endmodule

// File: rtl/query_enumerator.sv
// Enumerates (P1, P2, W) candidate tuples for an external query checker and
// queues each distinct satisfying (P1, P2) pair into a solution FIFO.
//   state | meaning
//   IDLE  | waiting for start, candidates hold
//   SCAN  | one candidate per cycle, W innermost, P1 outermost
//   DRAIN | scan finished, waiting for the FIFO to empty
module query_enumerator #(
  parameter int ATOM_BITS  = query_pkg::ATOM_BITS,
  parameter int NUM_ATOMS  = query_pkg::NUM_ATOMS,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [ATOM_BITS-1:0] cand_p1,
  output logic [ATOM_BITS-1:0] cand_p2,
  output logic [ATOM_BITS-1:0] cand_w,
  input  logic                 cand_ok,
  output logic                 sol_valid,
  input  logic                 sol_ready,
  output logic [ATOM_BITS-1:0] sol_p1,
  output logic [ATOM_BITS-1:0] sol_p2,
  output logic [CNT_BITS-1:0]  sol_count
);

  localparam logic [1:0] ST_IDLE  = query_pkg::IDLE;
  localparam logic [1:0] ST_SCAN  = query_pkg::SCAN;
  localparam logic [1:0] ST_DRAIN = query_pkg::DRAIN;
  localparam logic [ATOM_BITS-1:0] LAST = ATOM_BITS'(NUM_ATOMS - 1);

  logic [1:0]             state;
  logic                   fifo_full, fifo_empty;
  logic                   hit, stall, push, pop;
  logic                   last_w, last_p2, last_p1;
  logic [2*ATOM_BITS-1:0] sol_head;

  assign last_w  = (cand_w  == LAST);
  assign last_p2 = (cand_p2 == LAST);
  assign last_p1 = (cand_p1 == LAST);

  assign pop   = !fifo_empty && sol_ready;
  assign hit   = (state == ST_SCAN) && cand_ok && !abort;
  assign stall = hit && fifo_full && !pop;
  assign push  = hit && !stall;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DRAIN) && fifo_empty && !abort;
  assign sol_valid = !fifo_empty;
  assign sol_p1    = sol_head[2*ATOM_BITS-1:ATOM_BITS];
  assign sol_p2    = sol_head[ATOM_BITS-1:0];

  sol_fifo #(
    .WIDTH (2*ATOM_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_sol_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .din   ({cand_p1, cand_p2}),
    .dout  (sol_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cand_p1   <= '0;
      cand_p2   <= '0;
      cand_w    <= '0;
      sol_count <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SCAN;
            cand_p1   <= '0;
            cand_p2   <= '0;
            cand_w    <= '0;
            sol_count <= '0;
          end
        end
        ST_SCAN: begin
          if (push) begin
            if (sol_count != '1) sol_count <= sol_count + 1'b1;
            // a hit closes the pair: skip remaining witnesses
            if (last_p1 && last_p2) begin
              state <= ST_DRAIN;
            end else begin
              cand_w <= '0;
              if (last_p2) begin
                cand_p2 <= '0;
                cand_p1 <= cand_p1 + 1'b1;
              end else begin
                cand_p2 <= cand_p2 + 1'b1;
              end
            end
          end else if (!stall) begin
            if (last_p1 && last_p2 && last_w) begin
              state <= ST_DRAIN;
            end else if (last_w) begin
              cand_w <= '0;
              if (last_p2) begin
                cand_p2 <= '0;
                cand_p1 <= cand_p1 + 1'b1;
              end else begin
                cand_p2 <= cand_p2 + 1'b1;
              end
            end else begin
              cand_w <= cand_w + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_query_enumerator.sv
// Directed bench for query_enumerator driving the friends-program checker,
// an always-true and an always-false checker, plus stall/abort/reset sequences.
module tb_query_enumerator;
  import query_pkg::*;

  typedef struct {
    int mode;       // 0 friends, 1 always true, 2 always false
    int exp_done;   // cycle in which done pulses (start sampled in cycle 0)
    int exp_count;
    int exp_nsols;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  int         mode;
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  logic       start, abort, busy, done, cand_ok, sol_valid, sol_ready;
  logic [2:0] cand_p1, cand_p2, cand_w, sol_p1, sol_p2;
  logic [7:0] sol_count;

  logic       start1, abort1, busy1, done1, cand_ok1, sol_valid1, sol_ready1;
  logic [2:0] cand1_p1, cand1_p2, cand1_w, sol1_p1, sol1_p2;
  logic [7:0] sol_count1;

  vec_t vecs[3];

  always #5 clk = ~clk;

  function automatic logic hates(input int a, input int b);
    return (a == int'(SYM_ALICE) && b == int'(SYM_BOB)) ||
           (a == int'(SYM_BOB)   && b == int'(SYM_CHARLIE));
  endfunction

  function automatic logic query_ok(input int m, input int p1, input int p2, input int w);
    case (m)
      0:       return (hates(p1, w) && hates(w, p2)) || (hates(p2, w) && hates(w, p1));
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign cand_ok  = query_ok(mode, int'(cand_p1), int'(cand_p2), int'(cand_w));
  assign cand_ok1 = query_ok(mode, int'(cand1_p1), int'(cand1_p2), int'(cand1_w));

  query_enumerator dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .cand_p1(cand_p1), .cand_p2(cand_p2), .cand_w(cand_w), .cand_ok(cand_ok),
    .sol_valid(sol_valid), .sol_ready(sol_ready), .sol_p1(sol_p1), .sol_p2(sol_p2),
    .sol_count(sol_count)
  );

  query_enumerator #(.FIFO_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .cand_p1(cand1_p1), .cand_p2(cand1_p2), .cand_w(cand1_w), .cand_ok(cand_ok1),
    .sol_valid(sol_valid1), .sol_ready(sol_ready1), .sol_p1(sol1_p1), .sol_p2(sol1_p2),
    .sol_count(sol_count1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_scan(input vec_t v);
    int ep1[$], ep2[$], evis[$];
    int cyc_m, hitw, nsol, done_at, done_cnt, bad, wnz;
    mode  = v.mode;
    cyc_m = 1;
    for (int p1 = 0; p1 < 6; p1++)
      for (int p2 = 0; p2 < 6; p2++) begin
        hitw = -1;
        for (int w = 0; w < 6; w++)
          if (hitw < 0 && query_ok(v.mode, p1, p2, w)) hitw = w;
        if (hitw >= 0) begin
          ep1.push_back(p1);
          ep2.push_back(p2);
          evis.push_back(cyc_m + hitw + 1);
          cyc_m += hitw + 1;
        end else begin
          cyc_m += 6;
        end
      end
    sol_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    nsol = 0; done_at = -1; done_cnt = 0; bad = 0; wnz = 0;
    while (done_at < 0 && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy && (cand_p1 > 3'd5 || cand_p2 > 3'd5 || cand_w > 3'd5)) bad++;
      if (busy && cand_w != 3'd0) wnz++;
      if (sol_valid) begin
        if (nsol < ep1.size()) begin
          chk("sol_p1", sol_p1, ep1[nsol]);
          chk("sol_p2", sol_p2, ep2[nsol]);
          chk("sol_visible_cycle", cyc, evis[nsol]);
        end
        nsol++;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
    end
    chk("done_cycle", done_at, v.exp_done);
    @(negedge clk);
    cyc++;
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    chk("sol_count", sol_count, v.exp_count);
    chk("num_solutions", nsol, v.exp_nsols);
    chk("done_pulses", done_cnt, 1);
    chk("out_of_range_cand", bad, 0);
    if (v.mode == 1) chk("nonzero_witness", wnz, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{mode: 0, exp_done: 209, exp_count: 2,  exp_nsols: 2};
    vecs[1] = '{mode: 1, exp_done: 38,  exp_count: 36, exp_nsols: 36};
    vecs[2] = '{mode: 2, exp_done: 217, exp_count: 0,  exp_nsols: 0};

    rst = 1'b1; mode = 2; cyc = 0;
    start = 1'b0; abort = 1'b0; sol_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; sol_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sol_valid", sol_valid, 1'b0);
    chk("reset_cand", {cand_p1, cand_p2, cand_w}, 9'd0);
    chk("reset_sol_count", sol_count, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) run_scan(vecs[i]);

    // depth-1 FIFO: second hit stalls until the head is consumed
    mode = 0;
    @(negedge clk);
    start1 = 1'b1; cyc = 0;
    @(negedge clk);
    start1 = 1'b0; cyc = 1;
    step_to(75);
    chk("stall_cand", {cand1_p1, cand1_p2, cand1_w}, {3'd2, 3'd0, 3'd1});
    chk("stall_sol_valid", sol_valid1, 1'b1);
    chk("stall_head", {sol1_p1, sol1_p2}, {3'd0, 3'd2});
    chk("stall_count", sol_count1, 8'd1);
    sol_ready1 = 1'b1;
    step_to(76);
    chk("unstall_sol_valid", sol_valid1, 1'b1);
    chk("unstall_head", {sol1_p1, sol1_p2}, {3'd2, 3'd0});
    chk("unstall_count", sol_count1, 8'd2);
    chk("unstall_cand", {cand1_p1, cand1_p2, cand1_w}, {3'd2, 3'd1, 3'd0});
    n = 0;
    while (!done1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("stall_run_done", done1, 1'b1);
    sol_ready1 = 1'b0;

    // abort after one queued solution; start during SCAN is ignored
    mode = 0; sol_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; cyc = 0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    step_to(20);
    start = 1'b1;
    step_to(21);
    start = 1'b0;
    chk("start_ignored_cand", {cand_p1, cand_p2, cand_w}, {3'd0, 3'd4, 3'd0});
    chk("queued_head", {sol_p1, sol_p2}, {3'd0, 3'd2});
    step_to(40);
    abort = 1'b1;
    chk("abort_cycle_done", done, 1'b0);
    step_to(41);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sol_valid", sol_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sol_count", sol_count, 8'd1);
    chk("abort_cand_held", {cand_p1, cand_p2, cand_w}, {3'd1, 3'd1, 3'd1});
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);

    // asynchronous reset mid-scan, then rerun the friends scan
    sol_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; cyc = 0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    step_to(20);
    chk("pre_reset_count", sol_count, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_cand", {cand_p1, cand_p2, cand_w}, 9'd0);
    chk("async_rst_count", sol_count, 8'd0);
    chk("async_rst_sol_valid", sol_valid, 1'b0);
    chk("async_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_scan(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
